// File: rtl/wide_add_sequencer.sv
// Multi-word adder/subtractor that reuses one WIDTH-bit carry-select adder,
// one slice per clock, least-significant slice first.

module CarrySelectAdder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int LW = WIDTH / 2;
  localparam int UW = WIDTH - LW;

  logic [LW:0] w_lo;
  logic [UW:0] w_hi0;
  logic [UW:0] w_hi1;

  // Upper half is computed for both possible carries; the lower carry picks one.
  assign w_lo  = {1'b0, A[LW-1:0]} + {1'b0, B[LW-1:0]} + {{LW{1'b0}}, Cin};
  assign w_hi0 = {1'b0, A[WIDTH-1:LW]} + {1'b0, B[WIDTH-1:LW]};
  assign w_hi1 = {1'b0, A[WIDTH-1:LW]} + {1'b0, B[WIDTH-1:LW]} + {{UW{1'b0}}, 1'b1};

  assign S    = {(w_lo[LW] ? w_hi1[UW-1:0] : w_hi0[UW-1:0]), w_lo[LW-1:0]};
  assign Cout = w_lo[LW] ? w_hi1[UW] : w_hi0[UW];

endmodule

module wide_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] A,
  input  logic [WIDTH*WORDS-1:0] B,
  input  logic                   Cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] S,
  output logic                   Cout,
  output logic                   ovf,
  output logic                   zero
);

  localparam int TW = WIDTH * WORDS;
  localparam int KW = $clog2(WORDS);
  localparam logic [KW-1:0] LAST_K = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_a;
  logic [TW-1:0]   r_b;
  logic [TW-1:0]   r_s;
  logic [KW-1:0]   r_k;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;
  logic            r_zero;
  logic [WIDTH-1:0] w_aSlice;
  logic [WIDTH-1:0] w_bSlice;
  logic [WIDTH-1:0] w_sliceSum;
  logic            w_sliceCout;
  logic            w_accept;
  logic            w_last;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == RUN) && (r_k == LAST_K);

  always_comb begin
    w_aSlice = '0;
    w_bSlice = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (r_k == KW'(i)) begin
        w_aSlice = r_a[i*WIDTH +: WIDTH];
        w_bSlice = r_b[i*WIDTH +: WIDTH];
      end
    end
  end

  CarrySelectAdder #(.WIDTH(WIDTH)) u_adder (
    .A    (w_aSlice),
    .B    (w_bSlice),
    .Cin  (r_carry),
    .S    (w_sliceSum),
    .Cout (w_sliceCout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (r_k == LAST_K) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // B is stored already inverted for subtraction so the slice loop is a plain add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= sub ? ~B : B;
      r_k     <= '0;
      r_carry <= sub ? 1'b1 : Cin;
    end else if (r_state == RUN) begin
      for (int i = 0; i < WORDS; i++) begin
        if (r_k == KW'(i)) r_s[i*WIDTH +: WIDTH] <= w_sliceSum;
      end
      r_carry <= w_sliceCout;
      if (w_last) begin
        r_k    <= '0;
        r_cout <= w_sliceCout;
        r_ovf  <= (r_a[TW-1] == r_b[TW-1]) && (w_sliceSum[WIDTH-1] != r_a[TW-1]);
        r_zero <= ~|{w_sliceSum, r_s[TW-WIDTH-1:0]};
      end else begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  assign S    = r_s;
  assign Cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer (WIDTH=32, WORDS=4): a full-width
// reference add is queued at acceptance and compared when out_valid rises.

module tb_wide_add_sequencer;

  localparam int WIDTH = 32;
  localparam int WORDS = 4;
  localparam int TW    = WIDTH * WORDS;

  typedef struct packed {
    logic [TW-1:0] s;
    logic          cout;
    logic          ovf;
    logic          zero;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          inValid;
  logic          inReady;
  logic [TW-1:0] opA;
  logic [TW-1:0] opB;
  logic          cinIn;
  logic          subIn;
  logic          outValid;
  logic          outReady;
  logic [TW-1:0] sumOut;
  logic          coutOut;
  logic          ovfOut;
  logic          zeroOut;

  exp_t sbQueue[$];
  int   checks = 0;
  int   errors = 0;

  wide_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .A         (opA),
    .B         (opB),
    .Cin       (cinIn),
    .sub       (subIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .S         (sumOut),
    .Cout      (coutOut),
    .ovf       (ovfOut),
    .zero      (zeroOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [TW-1:0] randWide();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge,
  // leaving in_valid high with scrambled operands to prove they are ignored.
  task automatic applyStimulus(input logic [TW-1:0] a, input logic [TW-1:0] b,
                               input logic cin, input logic sb);
    exp_t          e;
    logic [TW:0]   full;
    logic [TW-1:0] effB;
    opA     = a;
    opB     = b;
    cinIn   = cin;
    subIn   = sb;
    inValid = 1'b1;
    checkVal("accept_ready", TW'(inReady), TW'(1));
    effB   = sb ? ~b : b;
    full   = {1'b0, a} + {1'b0, effB} + (TW+1)'(sb ? 1'b1 : cin);
    e.s    = full[TW-1:0];
    e.cout = full[TW];
    e.ovf  = (a[TW-1] == effB[TW-1]) && (full[TW-1] != a[TW-1]);
    e.zero = (full[TW-1:0] == '0);
    sbQueue.push_back(e);
    @(negedge clk);
    opA   = ~a;
    opB   = randWide();
    subIn = ~sb;
    cinIn = ~cin;
  endtask

  task automatic checkOutput(input string tag, input int holdCycles,
                             input logic [TW-1:0] nextA, input logic [TW-1:0] nextB);
    int   edges;
    exp_t e;
    edges = 0;
    while (outValid !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    inValid = 1'b0;
    checkVal({tag, "_latency"}, TW'(edges), TW'(WORDS));
    checkVal({tag, "_pending"}, TW'(sbQueue.size() > 0), TW'(1));
    e = '0;
    if (sbQueue.size() > 0) e = sbQueue.pop_front();
    checkVal({tag, "_S"}, sumOut, e.s);
    checkVal({tag, "_Cout"}, TW'(coutOut), TW'(e.cout));
    checkVal({tag, "_ovf"}, TW'(ovfOut), TW'(e.ovf));
    checkVal({tag, "_zero"}, TW'(zeroOut), TW'(e.zero));
    checkVal({tag, "_busy"}, TW'(inReady), TW'(0));
    for (int i = 0; i < holdCycles; i++) begin
      opA     = randWide();
      opB     = randWide();
      subIn   = 1'($urandom);
      inValid = (i % 2 == 0);
      @(negedge clk);
      checkVal({tag, "_hold_S"}, sumOut, e.s);
      checkVal({tag, "_hold_flags"}, TW'({coutOut, ovfOut, zeroOut}), TW'({e.cout, e.ovf, e.zero}));
      checkVal({tag, "_hold_valid"}, TW'({outValid, inReady}), TW'(2'b10));
    end
    if (holdCycles > 0) begin
      opA     = nextA;
      opB     = nextB;
      cinIn   = 1'b0;
      subIn   = 1'b0;
      inValid = 1'b1;
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkVal({tag, "_release"}, TW'({outValid, inReady}), TW'(2'b01));
  endtask

  initial begin
    logic [TW-1:0] allOnes;
    logic [TW-1:0] bpNextA;
    logic [TW-1:0] bpNextB;
    allOnes  = '1;
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    opA      = '0;
    opB      = '0;
    cinIn    = 1'b0;
    subIn    = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("reset_S", sumOut, '0);
    checkVal("reset_flags", TW'({coutOut, ovfOut, zeroOut}), TW'(0));
    checkVal("reset_handshake", TW'({outValid, inReady}), TW'(2'b01));
    rst = 1'b0;

    $display("[TB] directed vectors");
    applyStimulus(allOnes, TW'(1), 1'b0, 1'b0);
    checkOutput("ones_plus_one", 0, '0, '0);
    applyStimulus({32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, '0, 1'b1, 1'b0);
    checkOutput("carry_ripple", 0, '0, '0);
    applyStimulus(TW'(5), TW'(7), 1'b0, 1'b1);
    checkOutput("sub_5_7", 0, '0, '0);
    applyStimulus(TW'(7), TW'(5), 1'b1, 1'b1);
    checkOutput("sub_7_5", 0, '0, '0);
    applyStimulus({1'b0, {(TW-1){1'b1}}}, TW'(1), 1'b0, 1'b0);
    checkOutput("signed_ovf", 0, '0, '0);

    $display("[TB] random vectors");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(randWide(), randWide(), 1'($urandom), 1'($urandom));
      checkOutput("random", 0, '0, '0);
    end

    $display("[TB] backpressure");
    bpNextA = randWide();
    bpNextB = randWide();
    applyStimulus({32'h8000_0000, 96'h0}, {32'h8000_0000, 96'h1}, 1'b0, 1'b0);
    checkOutput("backpressure", 10, bpNextA, bpNextB);
    applyStimulus(bpNextA, bpNextB, 1'b0, 1'b0);
    checkOutput("after_bp", 0, '0, '0);

    $display("[TB] reset during run");
    applyStimulus(randWide() | TW'(1), randWide(), 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkVal("midrun_reset_S", sumOut, '0);
    checkVal("midrun_reset_handshake", TW'({outValid, inReady}), TW'(2'b01));
    checkVal("midrun_reset_flags", TW'({coutOut, ovfOut, zeroOut}), TW'(0));
    sbQueue.delete();
    @(negedge clk);
    rst     = 1'b0;
    inValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkVal("no_ghost_result", TW'(outValid), TW'(0));
    end
    applyStimulus(TW'(3), TW'(4), 1'b0, 1'b0);
    checkOutput("after_reset", 0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
